// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush control for the
// IF/ID and ID/EX pipeline latches, with saturating debug event counters.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      ifid_instr,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic             ex_branch_taken,
   output logic             stop,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             branch_reset,
   output logic             ifid_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;

   // The taken cycle itself is the first flush cycle, so FLUSH only has to
   // cover the remaining FLUSH_CYCLES-1 cycles.
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  fcnt;
   logic [2:0]  fcnt_nxt;

   logic [6:0]  opcode;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        uses_rs1;
   logic        uses_rs2;
   logic        lu;
   logic        flush_now;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign opcode = ifid_instr[6:0];
   assign rs1    = ifid_instr[19:15];
   assign rs2    = ifid_instr[24:20];

   // Only compare register fields the decoded instruction actually reads.
   assign uses_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign uses_rs2 = (opcode inside {OP_R, OP_S, OP_B});

   assign lu = idex_memread && (idex_rd != 5'd0) &&
               ((uses_rs1 && (rs1 == idex_rd)) || (uses_rs2 && (rs2 == idex_rd)));

   assign flush_now = ex_branch_taken || (state == FLUSH);

   // Flush FSM state and remaining-cycle register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         fcnt  <= 3'd0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Next-state logic: a new taken branch always restarts the flush window.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      case (state)
         IDLE: begin
            if (ex_branch_taken && MULTI_FLUSH) begin
               state_nxt = FLUSH;
               fcnt_nxt  = FLUSH_RELOAD;
            end
         end
         FLUSH: begin
            if (ex_branch_taken) begin
               fcnt_nxt = FLUSH_RELOAD;
            end else if (fcnt <= 3'd1) begin
               state_nxt = IDLE;
               fcnt_nxt  = 3'd0;
            end else begin
               fcnt_nxt = fcnt - 3'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            fcnt_nxt  = 3'd0;
         end
      endcase
   end

   // Latch controls: everything idle in reset, flush beats load-use stall.
   always_comb begin
      stop         = 1'b0;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      branch_reset = 1'b0;
      ifid_flush   = 1'b0;
      if (!reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (flush_now) begin
         branch_reset = 1'b1;
         ifid_flush   = 1'b1;
      end else if (lu) begin
         stop       = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end
   end

   // Saturating debug counters for stall cycles and taken-branch events.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (lu && !flush_now) begin
            stall_count <= sat_inc(stall_count);
         end
         if (ex_branch_taken) begin
            flush_count <= sat_inc(flush_count);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scenario tasks with a queue scoreboard of expected
// latch controls and counter values.
module tb_hazard_ctrl;

   localparam int FC = 2;
   localparam int CW = 4;

   // control vector order: {stop, pc_write, ifid_write, branch_reset, ifid_flush}
   localparam logic [4:0] C_NORM  = 5'b01100;
   localparam logic [4:0] C_STALL = 5'b10000;
   localparam logic [4:0] C_FLUSH = 5'b01111;
   localparam logic [4:0] C_RST   = 5'b00000;

   localparam logic [31:0] ADD_X5   = 32'h002280B3; // add x1,x5,x2
   localparam logic [31:0] ADD_X0   = 32'h002000B3; // add x1,x0,x2
   localparam logic [31:0] LUI_A    = 32'h000052B7; // lui x5,5
   localparam logic [31:0] LUI_B    = 32'h0002D2B7; // lui x5 with rs1 field = 5
   localparam logic [31:0] ADDI_X6  = 32'h00530093; // addi x1,x6,5 (rs2 field = 5)
   localparam logic [31:0] ADDI_X5  = 32'h00528093; // addi x1,x5,5
   localparam logic [31:0] SW_X5    = 32'h00532023; // sw x5,0(x6)
   localparam logic [31:0] NOP      = 32'h00000013;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   ifid_instr;
   logic          idex_memread;
   logic [4:0]    idex_rd;
   logic          ex_branch_taken;
   logic          stop;
   logic          pc_write;
   logic          ifid_write;
   logic          branch_reset;
   logic          ifid_flush;
   logic [CW-1:0] stall_count;
   logic [CW-1:0] flush_count;

   typedef struct packed {
      logic [4:0]    ctl;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic        mr;
      logic [4:0]  rd;
      logic        tk;
      logic [4:0]  ctl;
      int          sc;
      int          fc;
   } step_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk             (clk),
      .reset           (reset),
      .ifid_instr      (ifid_instr),
      .idex_memread    (idex_memread),
      .idex_rd         (idex_rd),
      .ex_branch_taken (ex_branch_taken),
      .stop            (stop),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .branch_reset    (branch_reset),
      .ifid_flush      (ifid_flush),
      .stall_count     (stall_count),
      .flush_count     (flush_count)
   );

   always #5 clk = ~clk;

   function automatic exp_t observed();
      return {stop, pc_write, ifid_write, branch_reset, ifid_flush, stall_count, flush_count};
   endfunction

   // drive one cycle of inputs after the edge, queue its expectation, settle
   task automatic drive_step(input step_t s);
      @(posedge clk);
      #1;
      ifid_instr      = s.instr;
      idex_memread    = s.mr;
      idex_rd         = s.rd;
      ex_branch_taken = s.tk;
      sb.push_back({s.ctl, CW'(s.sc), CW'(s.fc)});
      #3;
   endtask

   task automatic do_reset();
      reset           = 1'b0;
      ifid_instr      = NOP;
      idex_memread    = 1'b0;
      idex_rd         = 5'd0;
      ex_branch_taken = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      exp_t e;
      exp_t got;
      @(posedge clk);
      #2;
      reset           = 1'b0;
      ifid_instr      = ADD_X5;
      idex_memread    = 1'b1;
      idex_rd         = 5'd5;
      ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back({C_RST, CW'(0), CW'(0)});
         #1;
         e   = sb.pop_front();
         got = observed();
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL reset[%0d]: got %h want %h", i, got, e);
         end
         @(posedge clk);
         #2;
      end
      do_reset();
   endtask

   task automatic test_load_use();
      step_t s[$];
      exp_t  e;
      exp_t  got;
      do_reset();
      s.push_back('{ADD_X5,  1'b1, 5'd5, 1'b0, C_STALL, 0, 0});
      s.push_back('{ADD_X5,  1'b0, 5'd0, 1'b0, C_NORM,  1, 0});
      s.push_back('{SW_X5,   1'b1, 5'd5, 1'b0, C_STALL, 1, 0});
      s.push_back('{SW_X5,   1'b0, 5'd0, 1'b0, C_NORM,  2, 0});
      s.push_back('{ADDI_X5, 1'b1, 5'd5, 1'b0, C_STALL, 2, 0});
      s.push_back('{NOP,     1'b0, 5'd0, 1'b0, C_NORM,  3, 0});
      foreach (s[i]) begin
         drive_step(s[i]);
         e   = sb.pop_front();
         got = observed();
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL load_use[%0d]: got %h want %h", i, got, e);
         end
      end
   endtask

   task automatic test_no_stall();
      step_t s[$];
      exp_t  e;
      exp_t  got;
      do_reset();
      s.push_back('{ADD_X0,  1'b1, 5'd0, 1'b0, C_NORM, 0, 0});
      s.push_back('{LUI_A,   1'b1, 5'd5, 1'b0, C_NORM, 0, 0});
      s.push_back('{LUI_B,   1'b1, 5'd5, 1'b0, C_NORM, 0, 0});
      s.push_back('{ADDI_X6, 1'b1, 5'd5, 1'b0, C_NORM, 0, 0});
      s.push_back('{ADD_X5,  1'b0, 5'd5, 1'b0, C_NORM, 0, 0});
      s.push_back('{ADD_X5,  1'b1, 5'd6, 1'b0, C_NORM, 0, 0});
      s.push_back('{NOP,     1'b0, 5'd0, 1'b0, C_NORM, 0, 0});
      foreach (s[i]) begin
         drive_step(s[i]);
         e   = sb.pop_front();
         got = observed();
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL no_stall[%0d]: got %h want %h", i, got, e);
         end
      end
   endtask

   task automatic test_branch();
      step_t s[$];
      exp_t  e;
      exp_t  got;
      do_reset();
      s.push_back('{NOP, 1'b0, 5'd0, 1'b1, C_FLUSH, 0, 0});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_FLUSH, 0, 1});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_NORM,  0, 1});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_NORM,  0, 1});
      // back-to-back branches: the second one lands on the last flush cycle
      s.push_back('{NOP, 1'b0, 5'd0, 1'b1, C_FLUSH, 0, 1});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b1, C_FLUSH, 0, 2});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_FLUSH, 0, 3});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_NORM,  0, 3});
      foreach (s[i]) begin
         drive_step(s[i]);
         e   = sb.pop_front();
         got = observed();
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL branch[%0d]: got %h want %h", i, got, e);
         end
      end
   endtask

   task automatic test_simultaneous();
      step_t s[$];
      exp_t  e;
      exp_t  got;
      do_reset();
      s.push_back('{ADD_X5, 1'b1, 5'd5, 1'b1, C_FLUSH, 0, 0});
      s.push_back('{ADD_X5, 1'b1, 5'd5, 1'b0, C_FLUSH, 0, 1});
      s.push_back('{ADD_X5, 1'b1, 5'd5, 1'b0, C_STALL, 0, 1});
      s.push_back('{ADD_X5, 1'b0, 5'd5, 1'b0, C_NORM,  1, 1});
      foreach (s[i]) begin
         drive_step(s[i]);
         e   = sb.pop_front();
         got = observed();
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL simultaneous[%0d]: got %h want %h", i, got, e);
         end
      end
   endtask

   task automatic test_reset_mid_flush();
      step_t s[$];
      exp_t  e;
      exp_t  got;
      do_reset();
      s.push_back('{NOP, 1'b0, 5'd0, 1'b1, C_FLUSH, 0, 0});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_FLUSH, 0, 1});
      foreach (s[i]) begin
         drive_step(s[i]);
         e   = sb.pop_front();
         got = observed();
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL mid_flush_pre[%0d]: got %h want %h", i, got, e);
         end
      end
      // asynchronous reset in the middle of the FLUSH cycle
      reset = 1'b0;
      sb.push_back({C_RST, CW'(0), CW'(0)});
      #1;
      e   = sb.pop_front();
      got = observed();
      tests_run++;
      if (got !== e) begin
         tests_failed++;
         $display("FAIL mid_flush_reset: got %h want %h", got, e);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      s.delete();
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_NORM,  0, 0});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_NORM,  0, 0});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b1, C_FLUSH, 0, 0});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_FLUSH, 0, 1});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_NORM,  0, 1});
      foreach (s[i]) begin
         drive_step(s[i]);
         e   = sb.pop_front();
         got = observed();
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL mid_flush_post[%0d]: got %h want %h", i, got, e);
         end
      end
   endtask

   task automatic test_saturation();
      step_t s[$];
      exp_t  e;
      exp_t  got;
      do_reset();
      for (int k = 0; k < 20; k++)
         s.push_back('{ADD_X5, 1'b1, 5'd5, 1'b0, C_STALL, (k > 15) ? 15 : k, 0});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_NORM, 15, 0});
      for (int k = 0; k < 20; k++)
         s.push_back('{NOP, 1'b0, 5'd0, 1'b1, C_FLUSH, 15, (k > 15) ? 15 : k});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_FLUSH, 15, 15});
      s.push_back('{NOP, 1'b0, 5'd0, 1'b0, C_NORM,  15, 15});
      foreach (s[i]) begin
         drive_step(s[i]);
         e   = sb.pop_front();
         got = observed();
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL saturation[%0d]: got %h want %h", i, got, e);
         end
      end
   endtask

   initial begin
      reset           = 1'b0;
      ifid_instr      = NOP;
      idex_memread    = 1'b0;
      idex_rd         = 5'd0;
      ex_branch_taken = 1'b0;
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch();
      test_simultaneous();
      test_reset_mid_flush();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the control inputs of the IF/ID and ID/EX pipeline latches.
- Generates the ID/EX `stop` bubble and the PC/IF-ID write-enables on load-use hazards.
- Sequences the `branch_reset`/IF-ID flush on taken branches and jumps resolved in EX.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- FLUSH_CYCLES, 1, cycles `branch_reset`/`ifid_flush` stay asserted per taken branch (legal 1..7).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifid_instr  in  32  instruction currently held in the IF/ID latch.
- idex_memread  in  1  MemRead currently held in the ID/EX latch.
- idex_rd  in  5  destination register currently held in the ID/EX latch.
- ex_branch_taken  in  1  taken branch/JAL/JALR resolved in EX this cycle.
- stop  out  1  to ID/EX latch; inserts a bubble at the next edge.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID latch load enable.
- branch_reset  out  1  to ID/EX latch; flushes the instruction in decode.
- ifid_flush  out  1  to IF/ID latch; flushes the fetched instruction.
- stall_count  out  CNT_W  number of load-use stall cycles, saturating.
- flush_count  out  CNT_W  number of taken-branch events, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - Flush FSM goes to IDLE; flush counter and both event counters clear to 0.
  - Outputs while reset=0: stop=0, branch_reset=0, ifid_flush=0, pc_write=0, ifid_write=0.
- Field decode from ifid_instr: opcode=[6:0], rs1=[19:15], rs2=[24:20].
  - uses_rs1 = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - uses_rs2 = opcode in {0110011 R, 0100011 S, 1100011 B}.
- Load-use detect (combinational):
  - lu = idex_memread AND idex_rd!=0 AND ((uses_rs1 AND rs1==idex_rd) OR (uses_rs2 AND rs2==idex_rd)).
- Flush FSM, states IDLE and FLUSH, with a 3-bit remaining-cycles register `fcnt`:
  - flush_now = ex_branch_taken OR state==FLUSH.
  - IDLE, ex_branch_taken=1: if FLUSH_CYCLES>1, go to FLUSH with fcnt=FLUSH_CYCLES-1; else stay IDLE.
  - FLUSH: fcnt decrements each cycle; return to IDLE at the edge where fcnt reaches 0 (fcnt==1 → IDLE).
  - FLUSH, ex_branch_taken=1: reload fcnt=FLUSH_CYCLES-1 and stay in FLUSH.
- Output priority, flush over stall:
  - flush_now=1: branch_reset=1, ifid_flush=1, stop=0, pc_write=1, ifid_write=1. A load-use on the flushed instruction is ignored.
  - else lu=1: stop=1, pc_write=0, ifid_write=0, branch_reset=0, ifid_flush=0.
  - else: stop=0, pc_write=1, ifid_write=1, branch_reset=0, ifid_flush=0.
- Latency and timing:
  - All control outputs are combinational, so they act at the next rising edge.
  - A load-use stall lasts exactly 1 cycle: the bubble clears idex_memread and lu drops.
- Counters (registered):
  - stall_count += 1 on each cycle where (lu AND NOT flush_now).
  - flush_count += 1 on each cycle where ex_branch_taken=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-FLUSH aborts the sequence immediately (asynchronous); after release the FSM restarts in IDLE.

Test Plan:
- Load-use: ID/EX holds LW rd=x5 (memread=1); IF/ID holds ADD x1,x5,x2 (0x002280B3) → stop=1, pc_write=0, ifid_write=0 for one cycle; stall_count=1; next cycle memread=0 → stop=0.
- Register x0 and unused fields:
  - LW rd=x0 with IF/ID ADD x1,x0,x2 → no stall.
  - LW rd=x5 with IF/ID LUI x5 (0x000052B7) → no stall.
  - LW rd=x5 with IF/ID ADDI x1,x6,... where rs2 field=5 → no stall (rs2 unused).
- Taken branch with FLUSH_CYCLES=2: ex_branch_taken pulses 1 cycle → branch_reset=ifid_flush=1 for exactly 2 cycles, pc_write=1 throughout; flush_count=1.
- Simultaneous load-use and ex_branch_taken → branch_reset=1, stop=0, pc_write=1; stall_count unchanged.
- Reset low for 1 cycle during FLUSH → all outputs and counters 0 immediately; after release, no branch_reset until a new ex_branch_taken.
- Saturation with CNT_W=4: 20 consecutive stall cycles forced by holding idex_memread → stall_count holds at 15.
